regfile_wb_arb: RTL

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: register-file writeback arbiter between the pipeline (A,
// never back-pressured) and a long-latency unit (B, buffered in one entry).
// Optional starvation guard: define REGFILE_WB_STARVE_EN to count cycles a
// buffered B write is blocked by A and force a one-slot pipeline stall.
module regfile_wb_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        stall_o,
  output logic        wen_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        b_pend_o,
  output logic [4:0]  b_pend_addr_o
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, PEND, STALL} state_e;

  state_e      state_q, state_d;
  logic        full_q, full_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        accept, drain, starve_hit;

  // B is taken whenever the buffer is empty or is draining this cycle.
  assign b_ready = ~full_q | ~a_valid;
  assign accept  = b_valid & b_ready;
  assign drain   = full_q & ~a_valid;

  assign b_pend_o      = full_q;
  assign b_pend_addr_o = addr_q;

`ifdef REGFILE_WB_STARVE_EN
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic [3:0] cnt_q, cnt_d;

  // Wait counter: counts blocked PEND cycles, cleared outside PEND or on drain.
  always_comb begin
    cnt_d = cnt_q;
    if (drain || state_q != PEND) begin
      cnt_d = '0;
    end else if (a_valid) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit = (state_q == PEND) & a_valid & (cnt_q == STARVE_LAST);
  assign stall_o    = (state_q == STALL);
`else
  assign starve_hit = 1'b0;
  assign stall_o    = 1'b0;
`endif

  // Write port mux: A has priority, then the buffer; r0 writes are dropped.
  always_comb begin
    wen_o   = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (a_valid) begin
      wen_o   = (a_addr != 5'd0);
      waddr_o = a_addr;
      wdata_o = a_data;
    end else if (full_q) begin
      wen_o   = (addr_q != 5'd0);
      waddr_o = addr_q;
      wdata_o = data_q;
    end
  end

  // Buffer next-state: a fresh accept overrides a same-cycle drain.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      addr_d = b_addr;
      data_d = b_data;
    end else if (drain) begin
      full_d = 1'b0;
      addr_d = '0;
      data_d = '0;
    end
  end

  // FSM next-state: tracks buffer occupancy and the forced-stall condition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = PEND;
      end
      PEND: begin
        if (drain)           state_d = accept ? PEND : IDLE;
        else if (starve_hit) state_d = STALL;
      end
      STALL: begin
        if (drain) state_d = accept ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
